// File: rtl/cpu_pkg.sv
// Shared widths, FSM states and requester ids for the CPU memory arbiter.
package cpu_pkg;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the fetch and load/store requesters.
// ARB_ROUND_ROBIN_EN: ties go to the port not granted most recently; otherwise load/store wins.
module arb_pick
  import cpu_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic    clk,
  input  logic    reset,
  input  logic    take,
`endif
  input  logic    if_req,
  input  logic    ls_req,
  output logic    any_req,
  output req_id_e winner
);

  assign any_req = if_req | ls_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Low after reset so the fetch port wins the first tie.
  logic prefer_ls;

  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_ls <= 1'b0;
    end else if (take) begin
      prefer_ls <= (winner == REQ_IF);
    end
  end

  always_comb begin
    winner = REQ_IF;
    if (ls_req && (!if_req || prefer_ls)) begin
      winner = REQ_LS;
    end
  end
`else
  always_comb begin
    winner = ls_req ? REQ_LS : REQ_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter in front of a single-port synchronous memory.
// ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed load/store priority.
module mem_arbiter #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  import cpu_pkg::*;

  state_e            state;
  req_id_e           owner;
  logic              owner_we;
  logic              any_req;
  req_id_e           winner;
  logic              arbitrate;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign arbitrate = (state == IDLE) || (state == RESP);
  // The fetch port has no write path, so only a load/store winner can write.
  assign win_we    = (winner == REQ_LS) && ls_we;
  assign win_addr  = (winner == REQ_LS) ? ls_addr : if_addr;
  assign win_wdata = win_we ? ls_wdata : '0;

`ifdef ARB_ROUND_ROBIN_EN
  arb_pick u_arb_pick (
    .clk     (clk),
    .reset   (reset),
    .take    (arbitrate && any_req),
    .if_req  (if_req),
    .ls_req  (ls_req),
    .any_req (any_req),
    .winner  (winner)
  );
`else
  arb_pick u_arb_pick (
    .if_req  (if_req),
    .ls_req  (ls_req),
    .any_req (any_req),
    .winner  (winner)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= REQ_IF;
      owner_we  <= 1'b0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: pulse outputs are cleared first with non-blocking defaults; a later assignment in the same edge overrides, so each is high for exactly one cycle and no latch is implied.
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (state)
        ACCESS: begin
          state     <= RESP;
          if_rvalid <= (owner == REQ_IF);
          ls_rvalid <= (owner == REQ_LS);
        end
        default: begin
          if (arbitrate && any_req) begin
            state     <= ACCESS;
            owner     <= winner;
            owner_we  <= win_we;
            if_gnt    <= (winner == REQ_IF);
            ls_gnt    <= (winner == REQ_LS);
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Memory data is only valid in RESP, so read data is steered combinationally; writes answer 0.
  assign if_rdata = (if_rvalid && !owner_we) ? mem_rdata : '0;
  assign ls_rdata = (ls_rvalid && !owner_we) ? mem_rdata : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural single-port memory.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating tie-break.
module tb_mem_arbiter;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous single-port memory: read data one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ctl"}, 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we, busy}), 32'd0);
    check({tag, " addr"}, 32'(mem_addr), 32'd0);
    check({tag, " data"}, 32'(if_rdata | ls_rdata | mem_wdata), 32'd0);
  endtask

  task automatic ls_txn(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                        input string tag);
    ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    step();
    check({tag, " gnt"}, 32'({ls_gnt, if_gnt, mem_en, mem_we, busy}), 32'({1'b1, 1'b0, 1'b1, we, 1'b1}));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wdata));
    ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0;
    step();
    check({tag, " rvalid"}, 32'({ls_rvalid, if_rvalid, mem_en, ls_gnt}), 32'b1000);
    check({tag, " rdata"}, 32'(ls_rdata), 32'(exp_rdata));
    step();
    check_quiet({tag, " end"});
  endtask

  task automatic if_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_rdata,
                        input string tag);
    if_req = 1'b1; if_addr = addr;
    step();
    check({tag, " gnt"}, 32'({if_gnt, ls_gnt, mem_en, mem_we, busy}), 32'b10101);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(addr));
    step();
    if_req = 1'b0;
    check({tag, " rvalid"}, 32'({if_rvalid, ls_rvalid, mem_en, if_gnt}), 32'b1000);
    check({tag, " rdata"}, 32'(if_rdata), 32'(exp_rdata));
    step();
    check_quiet({tag, " end"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_ls;
    logic [DATA_W-1:0] exp_data;

    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (3) step();
    check_quiet("reset_state");
    reset = 1'b0;
    step();
    check_quiet("after_reset");

    // Memory contents are placed through the arbiter's own write path.
    ls_txn(1'b1, 10'd5, 19'h12345, 19'h0, "st5");
    ls_txn(1'b1, 10'd2, 19'h0AAAA, 19'h0, "st2");
    ls_txn(1'b1, 10'd3, 19'h05555, 19'h0, "st3");

    if_txn(10'd5, 19'h12345, "if_rd5");

    ls_txn(1'b1, 10'd1023, 19'h7FFFF, 19'h0, "st1023");
    ls_txn(1'b0, 10'd1023, 19'h0, 19'h7FFFF, "ld1023");
    ls_txn(1'b0, 10'd5, 19'h0, 19'h12345, "ld5");

    // Fetch request pulsed only while the arbiter is in ACCESS.
    ls_req = 1'b1; ls_addr = 10'd2;
    step();
    check("wd gnt", 32'({ls_gnt, if_gnt, mem_en}), 32'b101);
    ls_req = 1'b0; if_req = 1'b1; if_addr = 10'd7;
    step();
    if_req = 1'b0;
    check("wd resp", 32'({if_gnt, ls_rvalid, mem_en}), 32'b010);
    check("wd rdata", 32'(ls_rdata), 32'h0AAAA);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wd after", 32'({if_gnt, ls_gnt, mem_en, busy}), 32'd0);
    end

    // Reset held for three cycles while a fetch is in ACCESS.
    if_req = 1'b1; if_addr = 10'd5;
    step();
    check("rst access", 32'({if_gnt, mem_en, busy}), 32'b111);
    if_req = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst held", 32'({mem_en, busy, if_gnt, if_rvalid, ls_rvalid}), 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst after", 32'({if_rvalid, ls_rvalid, mem_en, busy}), 32'd0);
    end

    // Both requesters held high.
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'd2;
    if_req = 1'b1; if_addr = 10'd3;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ls = (k % 2) == 1;
`else
      exp_ls = 1'b1;
`endif
      exp_data = exp_ls ? 19'h0AAAA : 19'h05555;
      step();
      check($sformatf("both gnt%0d", k), 32'({if_gnt, ls_gnt, mem_en}), 32'({~exp_ls, exp_ls, 1'b1}));
      check($sformatf("both addr%0d", k), 32'(mem_addr), exp_ls ? 32'd2 : 32'd3);
      step();
      if (k == 3) begin
        ls_req = 1'b0; if_req = 1'b0;
      end
      check($sformatf("both rv%0d", k), 32'({if_rvalid, ls_rvalid, mem_en, if_gnt, ls_gnt}),
            32'({~exp_ls, exp_ls, 3'b000}));
      check($sformatf("both rdata%0d", k), 32'(exp_ls ? ls_rdata : if_rdata), 32'(exp_data));
    end
    step();
    check_quiet("both end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
